// File: rtl/aead_stream_sequencer_if.sv
// Word stream bundle between the memory datapath and the AEAD sequencer: input words in, processed words out.
// Latency: none, wires only; WORD_W must match the sequencer's WORD_W.
// Backpressure: s_ready gates the input side, m_ready gates the output side (valid/ready on both).
interface aead_stream_sequencer_if #(
    parameter int WORD_W = 64
);
    // Input side: words headed into the core, s_last marks the final word of a message.
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;

    // Output side: processed words in input order, m_last marks the final word of a message.
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    // master: the datapath that produces input words and consumes output words.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // slave: the sequencer.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/aead_stream_sequencer.sv
// Streaming front-end for chacha20_poly1305_core: packs words into 512-bit blocks, runs init/next/done, unpacks results.
// Latency: WPB fill cycles + 1 issue cycle + core latency + 1 capture cycle to the first m_valid of a full block.
// Backpressure: single-buffered; s_ready only in FILL, m_valid words held until m_ready, core waits bounded by TIMEOUT.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start, encdec           open a message (only while idle), mode latched at start
//   strm (slave modport)    s_valid/s_ready/s_data/s_last in, m_valid/m_ready/m_data/m_last out
//   core_*                  init/next/done pulses, encdec, packed block out; ready/valid/tag_ok, result, tag in
//   tag_valid, tag_out      one-cycle tag strobe and the captured tag
//   busy, err, blk_count    status: busy from start to tag, err 01=timeout 10=overflow, blocks issued
// Build option: define AEAD_SEQ_PERF_EN to add perf_cycles (start-to-tag cycle count, saturating).
module aead_stream_sequencer #(
    parameter int WORD_W     = 64,
    parameter int MAX_BLOCKS = 1024,
    parameter int TIMEOUT    = 4096
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               encdec,
    aead_stream_sequencer_if.slave             strm,
    output logic                               core_init,
    output logic                               core_next,
    output logic                               core_done,
    output logic                               core_encdec,
    output logic [511:0]                       core_data_in,
    input  logic                               core_ready,
    input  logic                               core_valid,
    input  logic                               core_tag_ok,
    input  logic [511:0]                       core_data_out,
    input  logic [127:0]                       core_tag,
    output logic                               tag_valid,
    output logic [127:0]                       tag_out,
    output logic                               busy,
    output logic [1:0]                         err,
    output logic [$clog2(MAX_BLOCKS+1)-1:0]    blk_count
`ifdef AEAD_SEQ_PERF_EN
    ,
    output logic [31:0]                        perf_cycles
`endif
);

    localparam int WPB  = 512 / WORD_W;          // words per block
    localparam int WIDX = $clog2(WPB);           // word index width
    localparam int BCW  = $clog2(MAX_BLOCKS + 1);
    localparam int TCW  = $clog2(TIMEOUT + 1);

    localparam logic [WIDX-1:0] LAST_SLOT = WIDX'(WPB - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT_V = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;
    localparam logic [2:0] ST_WAIT_T = 3'd7;

    logic [2:0]                    state;
    logic [2:0]                    state_nxt;

    // Word slot 0 is the most significant word of the block, so the packed
    // array index of word w is LAST_SLOT - w.
    logic [WPB-1:0][WORD_W-1:0]    fill_buf;
    logic [WPB-1:0][WORD_W-1:0]    out_buf;

    logic [WIDX-1:0]               wr_idx;     // next word slot to fill
    logic [WIDX-1:0]               rd_idx;     // next word slot to emit
    logic [WIDX-1:0]               last_idx;   // index of the final valid word of this block
    logic                          last_blk;   // this block carries the message's final word
    logic [TCW-1:0]                tcnt;       // cycles spent in the current waiting state

    logic start_acc;
    logic s_fire;
    logic m_fire;
    logic fill_done;
    logic drain_done;
    logic timed;
    logic tmo_hit;
    logic at_max;
    logic set_tmo;
    logic set_ovf;

    // ------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------
    // busy stays high through the tag_valid cycle so a start that lands
    // on the tag strobe is ignored rather than opening a new message.
    assign busy       = (state != ST_IDLE) || tag_valid;
    assign start_acc  = start && (state == ST_IDLE) && !tag_valid;

    assign strm.s_ready = (state == ST_FILL);
    assign s_fire       = strm.s_valid && strm.s_ready;
    assign fill_done    = s_fire && ((wr_idx == LAST_SLOT) || strm.s_last);

    assign strm.m_valid = (state == ST_DRAIN);
    assign strm.m_data  = out_buf[LAST_SLOT - rd_idx];
    assign strm.m_last  = strm.m_valid && last_blk && (rd_idx == last_idx);
    assign m_fire       = strm.m_valid && strm.m_ready;
    assign drain_done   = m_fire && (rd_idx == last_idx);

    assign core_data_in = fill_buf;

    // Only the states that wait on the core are bounded by TIMEOUT.
    assign timed   = (state == ST_INIT) || (state == ST_ISSUE) ||
                     (state == ST_WAIT_V) || (state == ST_WAIT_T);
    assign tmo_hit = timed && (tcnt == TCW'(TIMEOUT - 1));
    assign at_max  = (blk_count == BCW'(MAX_BLOCKS));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        set_tmo   = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_acc) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                if (core_ready) begin
                    state_nxt = ST_FILL;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    set_tmo   = 1'b1;
                end
            end
            ST_FILL: begin
                if (fill_done) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Overflow is decided before waiting on the core: the
                // block that would exceed MAX_BLOCKS is never issued.
                if (at_max) begin
                    state_nxt = ST_IDLE;
                    set_ovf   = 1'b1;
                end else if (core_ready) begin
                    state_nxt = ST_WAIT_V;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    set_tmo   = 1'b1;
                end
            end
            ST_WAIT_V: begin
                if (core_valid) begin
                    state_nxt = ST_DRAIN;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    set_tmo   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_nxt = last_blk ? ST_FIN : ST_FILL;
            end
            ST_FIN: begin
                state_nxt = ST_WAIT_T;
            end
            ST_WAIT_T: begin
                if (core_tag_ok) begin
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                    set_tmo   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, buffers and core pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            fill_buf    <= '0;
            out_buf     <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            last_idx    <= '0;
            last_blk    <= 1'b0;
            tcnt        <= '0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_done   <= 1'b0;
            core_encdec <= 1'b0;
            tag_valid   <= 1'b0;
            tag_out     <= '0;
            err         <= 2'b00;
            blk_count   <= '0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            core_done <= 1'b0;
            tag_valid <= 1'b0;
            state     <= state_nxt;

            // Timeout counter restarts on every state change.
            tcnt <= (timed && (state_nxt == state)) ? tcnt + 1'b1 : '0;

            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        core_encdec <= encdec;
                        err         <= 2'b00;
                        blk_count   <= '0;
                    end
                end
                ST_INIT: begin
                    if (core_ready) begin
                        core_init <= 1'b1;
                        fill_buf  <= '0;
                        wr_idx    <= '0;
                    end
                end
                ST_FILL: begin
                    if (s_fire) begin
                        fill_buf[LAST_SLOT - wr_idx] <= strm.s_data;
                        wr_idx <= wr_idx + 1'b1;
                        if (fill_done) begin
                            last_idx <= wr_idx;
                            last_blk <= strm.s_last;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!at_max && core_ready) begin
                        core_next <= 1'b1;
                        blk_count <= blk_count + 1'b1;
                    end
                end
                ST_WAIT_V: begin
                    if (core_valid) begin
                        out_buf <= core_data_out;
                        rd_idx  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (m_fire) begin
                        rd_idx <= rd_idx + 1'b1;
                        // Clearing here gives the next block its zero padding.
                        if (drain_done && !last_blk) begin
                            fill_buf <= '0;
                            wr_idx   <= '0;
                        end
                    end
                end
                ST_FIN: begin
                    core_done <= 1'b1;
                end
                ST_WAIT_T: begin
                    if (core_tag_ok) begin
                        tag_out   <= core_tag;
                        tag_valid <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (set_tmo) err <= 2'b01;
            if (set_ovf) err <= 2'b10;
        end
    end

`ifdef AEAD_SEQ_PERF_EN
    // Counts every cycle the message is in flight; the value holds once the
    // sequencer is back in IDLE so software can read it after tag_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_cycles <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
        end else if ((state != ST_IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aead_stream_sequencer.sv
// Randomized bench for aead_stream_sequencer with a behavioural core model and a word-level reference model.
// Latency: core model answers 10 cycles after core_next and 3 cycles after core_done.
// Backpressure: random s_valid gaps, random m_ready, one long m_ready stall, random core_ready drops.
module tb_aead_stream_sequencer;

    localparam int          WORD_W = 64;
    localparam int          BUD    = 2000;
    localparam logic [63:0] MASK_W = 64'hFFFF0000FFFF0000;
    localparam logic [511:0] MASK_BLK = {8{MASK_W}};

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         encdec;
    logic         core_init, core_next, core_done, core_encdec;
    logic [511:0] core_data_in;
    logic         core_ready, core_valid, core_tag_ok;
    logic [511:0] core_data_out;
    logic [127:0] core_tag;
    logic         tag_valid;
    logic [127:0] tag_out;
    logic         busy;
    logic [1:0]   err;
    logic [1:0]   blk_count;
`ifdef AEAD_SEQ_PERF_EN
    logic [31:0]  perf_cycles;
`endif

    aead_stream_sequencer_if #(.WORD_W(WORD_W)) strm ();

    aead_stream_sequencer #(
        .WORD_W     (WORD_W),
        .MAX_BLOCKS (2),
        .TIMEOUT    (64)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .encdec        (encdec),
        .strm          (strm),
        .core_init     (core_init),
        .core_next     (core_next),
        .core_done     (core_done),
        .core_encdec   (core_encdec),
        .core_data_in  (core_data_in),
        .core_ready    (core_ready),
        .core_valid    (core_valid),
        .core_tag_ok   (core_tag_ok),
        .core_data_out (core_data_out),
        .core_tag      (core_tag),
        .tag_valid     (tag_valid),
        .tag_out       (tag_out),
        .busy          (busy),
        .err           (err),
        .blk_count     (blk_count)
`ifdef AEAD_SEQ_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference data: message words, collected outputs, core-model bookkeeping.
    logic [63:0]  in_q[$];
    logic [63:0]  out_d[$];
    logic         out_l[$];
    logic [127:0] cur_tag;
    int           blk_idx, n_init, n_next, n_done;
    bit           no_valid;

    // Expected packed block b: words MSB-first, zero beyond the message end.
    function automatic logic [511:0] exp_block(input int b);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            if (b * 8 + j < in_q.size()) r[511 - 64 * j -: 64] = in_q[b * 8 + j];
        return r;
    endfunction

    // Behavioural core: XOR mask, 10-cycle result latency, tag 3 cycles after done.
    logic [511:0] resp;
    int           vcnt, tcnt_m;
    bit           pend_v, pend_t;

    always @(negedge clk) begin
        core_valid  = 1'b0;
        core_tag_ok = 1'b0;
        if (!reset_n) begin
            pend_v     = 1'b0;
            pend_t     = 1'b0;
            core_ready = 1'b1;
        end else begin
            core_ready = ($urandom_range(0, 3) != 0);
            if (core_init) n_init++;
            if (core_next) begin
                n_next++;
                chk("core_data_in", core_data_in, exp_block(blk_idx));
                blk_idx++;
                resp   = core_data_in ^ MASK_BLK;
                pend_v = 1'b1;
                vcnt   = 10;
            end else if (pend_v) begin
                vcnt--;
                if (vcnt == 0) begin
                    pend_v = 1'b0;
                    if (!no_valid) begin
                        core_valid    = 1'b1;
                        core_data_out = resp;
                    end
                end
            end
            if (core_done) begin
                n_done++;
                pend_t = 1'b1;
                tcnt_m = 3;
            end else if (pend_t) begin
                tcnt_m--;
                if (tcnt_m == 0) begin
                    pend_t      = 1'b0;
                    core_tag_ok = 1'b1;
                    core_tag    = cur_tag;
                end
            end
        end
    end

    task automatic pulse_start(input logic mode);
        cur_tag = {$urandom, $urandom, $urandom, $urandom};
        blk_idx = 0;
        n_init  = 0;
        n_next  = 0;
        n_done  = 0;
        out_d.delete();
        out_l.delete();
        @(negedge clk);
        start  = 1'b1;
        encdec = mode;
        @(negedge clk);
        start  = 1'b0;
        encdec = ~mode;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err, 0);
    endtask

    task automatic send_words();
        int cyc;
        for (int i = 0; i < in_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                strm.s_valid = 1'b0;
                @(negedge clk);
            end
            strm.s_valid = 1'b1;
            strm.s_data  = in_q[i];
            strm.s_last  = (i == in_q.size() - 1);
            cyc = 0;
            while (!strm.s_ready && cyc < BUD) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= BUD) begin
                chk("s_ready_timeout", strm.s_ready, 1);
                break;
            end
            @(negedge clk);
        end
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
    endtask

    task automatic collect(input int n, input int stall_at);
        int          got, cyc;
        bit          stalled, ok;
        logic [63:0] hold_d;
        got = 0;
        cyc = 0;
        stalled = 0;
        while (got < n && cyc < BUD) begin
            if (!stalled && got == stall_at && strm.m_valid) begin
                strm.m_ready = 1'b0;
                hold_d = strm.m_data;
                ok = 1;
                repeat (20) begin
                    @(negedge clk);
                    cyc++;
                    if (strm.m_valid !== 1'b1 || strm.m_data !== hold_d || strm.s_ready !== 1'b0) ok = 0;
                end
                chk("stall_hold", ok, 1);
                stalled = 1;
            end
            strm.m_ready = ($urandom_range(0, 3) != 0);
            if (strm.m_valid && strm.m_ready) begin
                out_d.push_back(strm.m_data);
                out_l.push_back(strm.m_last);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        strm.m_ready = 1'b0;
        chk("rx_count", got, n);
    endtask

    task automatic check_outputs(input bit has_last);
        for (int i = 0; i < out_d.size() && i < in_q.size(); i++) begin
            chk("m_data", out_d[i], in_q[i] ^ MASK_W);
            chk("m_last", out_l[i], has_last && (i == in_q.size() - 1));
        end
    endtask

    // Full message through to the tag; poke drives start on the tag_valid cycle.
    task automatic run_msg(input logic mode, input int stall_at, input bit poke);
        int n, nb, cyc;
        n  = in_q.size();
        nb = (n + 7) / 8;
        pulse_start(mode);
        fork
            send_words();
            collect(n, stall_at);
        join
        cyc = 0;
        while (!tag_valid && cyc < BUD) begin
            @(negedge clk);
            cyc++;
        end
        chk("tag_valid_seen", tag_valid, 1);
        chk("tag_out", tag_out, cur_tag);
        chk("busy_on_tag", busy, 1);
        chk("core_encdec", core_encdec, mode);
        chk("blk_count", blk_count, nb);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_tag", busy, 0);
        chk("n_init", n_init, 1);
        chk("n_next", n_next, nb);
        chk("n_done", n_done, 1);
        check_outputs(1);
    endtask

    task automatic fill_random(input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back({$urandom, $urandom});
    endtask

    initial begin
        int cyc, k, n;
        bit ok;
        reset_n = 1'b0;
        start = 1'b0;
        encdec = 1'b0;
        no_valid = 1'b0;
        core_ready = 1'b1;
        core_valid = 1'b0;
        core_tag_ok = 1'b0;
        core_data_out = '0;
        core_tag = '0;
        strm.s_valid = 1'b0;
        strm.s_data = '0;
        strm.s_last = 1'b0;
        strm.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_core_data_in", core_data_in, 0);
        chk("rst_tag_out", tag_out, 0);
        chk("rst_outputs", {strm.s_ready, strm.m_valid, strm.m_last, tag_valid, core_init, core_next, core_done, core_encdec}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // s_valid while idle must not be taken.
        strm.s_valid = 1'b1;
        strm.s_data = 64'h1;
        ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (strm.s_ready !== 1'b0 || busy !== 1'b0) ok = 0;
        end
        strm.s_valid = 1'b0;
        chk("idle_no_accept", ok, 1);

        // Two exact blocks of one pattern, long stall mid-drain, start poked on tag_valid.
        in_q.delete();
        for (int i = 0; i < 16; i++) in_q.push_back(64'hcafebabedeadbeef);
        run_msg(1'b0, 5, 1);

        // Short message: padding checked at core_next.
        fill_random(3);
        run_msg(1'b1, -1, 0);

        // Randomized messages.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 16);
            fill_random(n);
            run_msg(1'($urandom_range(0, 1)), (r % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1, r[0]);
        end

        // Core never returns a result: timeout after 64 cycles in WAIT_V.
        fill_random(8);
        no_valid = 1'b1;
        pulse_start(1'b0);
        send_words();
        cyc = 0;
        while (!core_next && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_next_seen", core_next, 1);
        k = 0;
        while (err == 2'b00 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycles", k, 64);
        chk("tmo_err", err, 2'b01);
        chk("tmo_busy", busy, 0);
        no_valid = 1'b0;
        repeat (15) @(negedge clk);
        fill_random(5);
        run_msg(1'b0, -1, 0);

        // Reset while waiting on the core abandons the message.
        fill_random(8);
        pulse_start(1'b1);
        send_words();
        cyc = 0;
        while (!core_next && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrst_busy", busy, 0);
        chk("wrst_err_blk", {err, blk_count}, 0);
        chk("wrst_core_data_in", core_data_in, 0);
        chk("wrst_tag_out", tag_out, 0);
        chk("wrst_m_data", strm.m_data, 0);
        chk("wrst_outputs", {strm.s_ready, strm.m_valid, strm.m_last, tag_valid, core_init, core_next, core_done, core_encdec}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("wrst_no_done", n_done, 0);
        fill_random(11);
        run_msg(1'b1, -1, 0);

        // Overflow: 17 words with MAX_BLOCKS=2 fails at the third issue.
        fill_random(17);
        pulse_start(1'b0);
        fork
            send_words();
            collect(16, -1);
        join
        cyc = 0;
        while (err == 2'b00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ovf_err", err, 2'b10);
        chk("ovf_busy", busy, 0);
        chk("ovf_blk_count", blk_count, 2);
        repeat (15) @(negedge clk);
        chk("ovf_n_next", n_next, 2);
        chk("ovf_n_done", n_done, 0);
        check_outputs(0);

        fill_random(9);
        run_msg(1'b0, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
